mem_test_initiator: RTL and testbench

MEM_TEST_INITIATOR -- requirements
Module: mem_test_initiator

---
 rtl/mem_test_initiator.sv | 153 +++++++++++++++
 tb/tb_mem_test_initiator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_initiator.sv
// March-style memory test master: write/read pattern then its complement
// over every address, with mismatch capture and per-request timeout.
module mem_test_initiator #(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 1024,
  parameter int               ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] PATTERN    = WIDTH'(16'hA5A5),
  parameter int               TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wr_data_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [WIDTH-1:0]      fail_data_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0]      fd_q, fd_d;
  logic                  to_q, to_d;
  logic                  pass_q, pass_d;

  logic [WIDTH-1:0]      pat;
  logic [WIDTH-1:0]      exp_w;
  logic                  last_a;
  logic                  is_rd;

  // phase bit 1 selects the complemented pattern, bit 0 selects read
  assign pat    = PATTERN ^ WIDTH'(addr_q);
  assign exp_w  = phase_q[1] ? ~pat : pat;
  assign last_a = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign is_rd  = phase_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      addr_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    to_d    = to_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = REQ;
          phase_d = '0;
          addr_d  = '0;
          tcnt_d  = '0;
          err_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
          to_d    = 1'b0;
          pass_d  = 1'b0;
        end
      end
      REQ: begin
        if (ready_i) begin
          state_d = GAP;
          if (is_rd && (rd_data_i != exp_w)) begin
            if (err_q == 16'd0) begin
              fa_d = addr_q;
              fd_d = rd_data_i;
            end
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      GAP: begin
        if (!ready_i) begin
          if ((phase_q == 2'd3) && last_a) begin
            state_d = DONE;
            pass_d  = (err_q == 16'd0) && !to_q;
          end else begin
            state_d = REQ;
            tcnt_d  = '0;
            addr_d  = last_a ? '0 : addr_q + 1'b1;
            if (last_a) phase_d = phase_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_o     = (state_q == REQ);
  assign busy_o      = (state_q == REQ) || (state_q == GAP);
  assign done_o      = (state_q == DONE);
  assign wr_rd_o     = valid_o && !is_rd;
  assign wr_data_o   = wr_rd_o ? exp_w : '0;
  assign addr_o      = addr_q;
  assign pass_o      = pass_q;
  assign timeout_o   = to_q;
  assign err_count_o = err_q;
  assign fail_addr_o = fa_q;
  assign fail_data_o = fd_q;

endmodule

// File: tb/tb_mem_test_initiator.sv
// Bench for mem_test_initiator: ideal one-cycle memory with optional
// stuck-at-0 bit, checked against a loop-level model of the test run.
module tb_mem_test_initiator;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [W-1:0]  rd_data;
  logic          valid, wr_rd, busy, done, pass, tmo;
  logic [AW-1:0] addr, fa;
  logic [W-1:0]  wr_data, fd;
  logic [15:0]   err;
  logic [57:0]   outs;

  logic [W-1:0]  mem [D];
  bit            tie_low = 1'b0;
  bit            stuck_en = 1'b0;
  int            stuck_a = 0;
  int            stuck_b = 0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_test_initiator #(
    .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW),
    .PATTERN(16'hA5A5), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst_n), .start_i(start),
    .valid_o(valid), .wr_rd_o(wr_rd), .addr_o(addr),
    .wr_data_o(wr_data), .ready_i(ready), .rd_data_i(rd_data),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .timeout_o(tmo), .err_count_o(err),
    .fail_addr_o(fa), .fail_data_o(fd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ready <= valid && !tie_low;
    if (valid && ready && wr_rd) mem[addr] <= wr_data;
  end

  assign rd_data = (stuck_en && (int'(addr) == stuck_a))
                 ? (mem[addr] & ~(16'(1) << stuck_b))
                 : mem[addr];

  assign outs = {valid, wr_rd, addr, wr_data, busy, done,
                 pass, tmo, err, fa, fd};

  // Whole-run result from the test algorithm itself
  function automatic void model(input bit en, input int sa, input int sb,
                                output int e, output int xa,
                                output logic [15:0] xd);
    logic [15:0] m [D];
    logic [15:0] dv, rv;
    e = 0; xa = 0; xd = '0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int a = 0; a < D; a++) begin
        dv = 16'hA5A5 ^ 16'(a);
        if (ph >= 2) dv = ~dv;
        if (ph % 2 == 0) m[a] = dv;
        else begin
          rv = m[a];
          if (en && a == sa) rv[sb] = 1'b0;
          if (rv != dv) begin
            if (e == 0) begin xa = a; xd = rv; end
            e++;
          end
        end
      end
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL reset_hold: got %h want 0", outs);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: busy %b done %b want 0 0", busy, done);
    end
    pulse_start();
    repeat ($urandom_range(2, 30)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", outs);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_clean_run();
    int e, xa; logic [15:0] xd;
    stuck_en = 1'b0; tie_low = 1'b0;
    model(1'b0, 0, 0, e, xa, xd);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    pulse_start();
    n_cmp++;
    if ({valid, wr_rd, addr, wr_data} !== {1'b1, 1'b1, 2'd0, 16'hA5A5}) begin
      n_bad++;
      $display("FAIL first_req: got v%b w%b a%0d d%h want v1 w1 a0 dA5A5",
               valid, wr_rd, addr, wr_data);
    end
    repeat (63) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL clean_early_done: got %b want 0", done);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, pass, tmo, err} !== {1'b1, 1'b0, e == 0, 1'b0, 16'(e)}) begin
      n_bad++;
      $display("FAIL clean_result: done %b busy %b pass %b tmo %b err %0d want 1 0 1 0 %0d",
               done, busy, pass, tmo, err, e);
    end
  endtask

  task automatic test_stuck_bit();
    int e, xa; logic [15:0] xd; bit ok;
    stuck_en = 1'b1; stuck_a = 2; stuck_b = 0;
    pulse_start();
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL stuck_done: done %b want 1", done);
    end
    n_cmp++;
    if ({err, fa, fd, pass} !== {16'd1, 2'd2, 16'hA5A6, 1'b0}) begin
      n_bad++;
      $display("FAIL stuck_fixed: err %0d fa %0d fd %h pass %b want 1 2 A5A6 0",
               err, fa, fd, pass);
    end
    for (int k = 0; k < 4; k++) begin
      stuck_a = $urandom_range(0, D - 1);
      stuck_b = $urandom_range(0, W - 1);
      model(1'b1, stuck_a, stuck_b, e, xa, xd);
      pulse_start();
      wait_done(ok);
      n_cmp++;
      if (!ok || err !== 16'(e) || fa !== AW'(xa) || fd !== xd || pass !== (e == 0)) begin
        n_bad++;
        $display("FAIL stuck_rand a%0d b%0d: err %0d fa %0d fd %h pass %b want %0d %0d %h %b",
                 stuck_a, stuck_b, err, fa, fd, pass, e, xa, xd, e == 0);
      end
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_restart();
    pulse_start();
    n_cmp++;
    if ({done, pass, tmo, err, fa, fd} !== '0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_clear: done %b pass %b tmo %b err %0d fa %0d fd %h busy %b",
               done, pass, tmo, err, fa, fd, busy);
    end
    repeat (64) @(negedge clk);
    n_cmp++;
    if ({done, pass, err} !== {1'b1, 1'b1, 16'd0}) begin
      n_bad++; $display("FAIL restart_run: done %b pass %b err %0d want 1 1 0", done, pass, err);
    end
  endtask

  task automatic test_timeout();
    tie_low = 1'b1;
    pulse_start();
    repeat (TO - 1) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b1 || tmo !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: valid %b tmo %b want 1 0", valid, tmo);
    end
    @(negedge clk);
    n_cmp++;
    if ({valid, tmo, done, pass, busy} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout: valid %b tmo %b done %b pass %b busy %b want 0 1 1 0 0",
               valid, tmo, done, pass, busy);
    end
    tie_low = 1'b0;
    pulse_start();
    n_cmp++;
    if (tmo !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: tmo %b done %b want 0 0", tmo, done);
    end
    repeat (64) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int r;
    r = $urandom_range(0, 3);
    pulse_start();
    repeat (36 + r) @(negedge clk);
    n_cmp++;
    if (addr !== 2'd1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_pos: addr %0d busy %b want 1 1", addr, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL mid_reset: got %h want 0", outs);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    pulse_start();
    n_cmp++;
    if ({valid, wr_rd, addr, wr_data} !== {1'b1, 1'b1, 2'd0, 16'hA5A5}) begin
      n_bad++;
      $display("FAIL mid_restart: v%b w%b a%0d d%h want v1 w1 a0 dA5A5",
               valid, wr_rd, addr, wr_data);
    end
    repeat (64) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_bad++; $display("FAIL mid_rerun: done %b pass %b want 1 1", done, pass);
    end
  endtask

  task automatic test_busy_start();
    int k;
    k = $urandom_range(16, 30);
    pulse_start();
    repeat (k) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || wr_rd === 1'b1) begin
      n_bad++; $display("FAIL busy_start_p1: busy %b wr_rd %b want 1 0", busy, wr_rd);
    end
    repeat (63 - (k + 1)) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL busy_early: done %b want 0", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_bad++; $display("FAIL busy_total: done %b pass %b want 1 1", done, pass);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_restart();
    test_timeout();
    test_reset_mid_run();
    test_busy_start();
    test_clean_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
